// File: rtl/data_mem_unit.sv
// data_mem_unit: multi-cycle RV32 data-memory responder with byte/half/word
// sizing, sign/zero extension and byte-lane write merging.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned access trapping).
module data_mem_unit #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        misaligned
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic            op_wr;
  logic [2:0]      f3_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            req;
  logic            fire;
  logic [AW-1:0]   word_idx;
  logic            illegal;
  logic            mis;
  logic            blocked;
  logic [3:0]      lane_mask;
  logic [31:0]     wlanes;
  logic [31:0]     rword;
  logic [7:0]      bsel;
  logic [15:0]     hsel;
  logic [31:0]     ld_val;
  logic            unused_addr_hi;

  assign req            = mem_read | mem_write;
  assign fire           = (state == S_BUSY) && (cnt == '0);
  assign word_idx       = addr_q[AW+1:2];
  assign unused_addr_hi = ^addr[31:AW+2];
  assign illegal        = (f3_q == 3'b011) || (f3_q == 3'b110) || (f3_q == 3'b111);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis = !illegal &&
               (((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00)));
`else
  assign mis = 1'b0;
`endif

  assign blocked = illegal | mis;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req) state_nxt = S_BUSY;
      S_BUSY:  if (cnt == '0) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Combinational stall: freeze requestor from acceptance through last BUSY cycle
  always_comb begin
    stall = 1'b0;
    case (state)
      S_IDLE:  stall = req;
      S_BUSY:  stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  // Store lane enables and lane-replicated store data
  always_comb begin
    lane_mask = 4'b0000;
    wlanes    = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        lane_mask = 4'(4'b0001 << addr_q[1:0]);
        wlanes    = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
        wlanes    = {2{wdata_q[15:0]}};
      end
      2'b10:   lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  end

  assign rword = mem[word_idx];
  assign bsel  = 8'(rword >> {addr_q[1:0], 3'b000});
  assign hsel  = addr_q[1] ? rword[31:16] : rword[15:0];

  // Load extraction and extension
  always_comb begin
    ld_val = 32'h0;
    case (f3_q)
      3'b000:  ld_val = {{24{bsel[7]}}, bsel};
      3'b100:  ld_val = {24'h0, bsel};
      3'b001:  ld_val = {{16{hsel[15]}}, hsel};
      3'b101:  ld_val = {16'h0, hsel};
      3'b010:  ld_val = rword;
      default: ld_val = 32'h0;
    endcase
  end

  // Request capture, latency counter and registered response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      op_wr      <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      rdata      <= 32'h0;
    end else begin
      done       <= fire;
      misaligned <= fire & mis;
      if ((state == S_IDLE) && req) begin
        cnt     <= CW'(LATENCY - 1);
        op_wr   <= mem_write;
        f3_q    <= funct3;
        addr_q  <= addr[AW+1:0];
        wdata_q <= wdata;
      end else if ((state == S_BUSY) && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
      end
      if (fire && (!op_wr || blocked)) rdata <= blocked ? 32'h0 : ld_val;
    end
  end

  // Array write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (fire && op_wr && !blocked) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_mask[i]) mem[word_idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Multi-cycle data-memory responder for the single-issue RV32 core. Services the load/store requests that the decode stage raises through `mem_read` / `mem_write`, using a word-addressed internal array. It performs RV32I sub-word sizing: byte/half/word accesses, sign or zero extension, and byte-lane write merging. It holds the pipeline through `stall` until the access completes, and signals completion with a one-cycle `done` pulse.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024 — array depth in 32-bit words; power of two.
- `LATENCY`, 2 — number of BUSY cycles per access; legal range 1..15.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `mem_read`  in  1  — load request from decode.
- `mem_write`  in  1  — store request from decode.
- `funct3`  in  3  — access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  32  — byte address from the ALU.
- `wdata`  in  32  — store data; the low bytes are used for B and H accesses.
- `rdata`  out  32  — extended load result; valid while `done`=1.
- `stall`  out  1  — requestor must freeze and hold all inputs stable.
- `done`  out  1  — access complete, one-cycle pulse.
- `misaligned`  out  1  — misaligned access flag, pulses with `done` (see Configuration).

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: when `mem_read|mem_write`=1, latch `addr`, `wdata`, `funct3` and the operation type, load the counter with `LATENCY-1`, and go to BUSY.
- If `mem_read` and `mem_write` are both 1, the access is a store; the load is dropped.
- BUSY: decrement the counter. At 0, perform the access and go to RESP.
- Access for a store:
  - Word index is `addr[log2(DEPTH_WORDS)+1:2]`; higher address bits are ignored, so out-of-range addresses wrap.
  - SB writes lane `addr[1:0]`. SH writes lanes {`addr[1]`*2, +1}. SW writes all four lanes.
  - Unwritten lanes are preserved.
- Access for a load: select the addressed byte/half/word, then sign-extend (B, H) or zero-extend (BU, HU). Register the result into `rdata`.
- Illegal `funct3` (011, 110, 111): no array change, `rdata`=0, `done` still pulses.
- RESP: `done`=1 for one cycle, then go to IDLE unconditionally. Request inputs are ignored in RESP; they are still asserted by the pipeline, which advances at the end of this cycle.
- Reset:
  - Outputs: `rdata`=0, `done`=0, `stall`=0, `misaligned`=0; state returns to IDLE.
  - Asserting `rst` mid-access discards the pending store; the array is not written.
  - Array contents are not cleared by reset.

## Timing
- `stall` is combinational:
  - 1 in IDLE when `mem_read|mem_write`=1;
  - 1 throughout BUSY;
  - 0 in RESP and in an idle IDLE.
- Request sampled in cycle 0 → BUSY occupies cycles 1..LATENCY → `done` in cycle LATENCY+1. Total latency is LATENCY+1 cycles; `stall` is high for cycles 0..LATENCY.
- The array write and the `rdata` register update occur on the edge that ends the last BUSY cycle.
- `rdata` holds its value until the next load completes. Stores leave `rdata` unchanged.
- A new request in the cycle after RESP is accepted immediately. There are no idle bubbles beyond RESP, so back-to-back throughput is one access per LATENCY+2 cycles.
- `done` and `misaligned` are registered outputs.

## Configuration
- Macro `DMEM_MISALIGN_TRAP_EN` defined:
  - An access is misaligned when H/HU/SH has `addr[0]`=1, or W/SW has `addr[1:0]`≠0.
  - A misaligned access performs no array write, returns `rdata`=0, and pulses `misaligned`=1 together with `done`.
  - Timing is unchanged.
- Macro undefined:
  - `misaligned` is tied to 0.
  - Offending low address bits are ignored: H uses `addr[1]` only, W ignores `addr[1:0]`.
  - The access proceeds normally.

## Test plan
- Reset then idle: `rst`=1 mid-BUSY of SW 0xDEADBEEF @0x10 → outputs 0, IDLE; a later LW @0x10 returns the prior contents, not 0xDEADBEEF.
- Word path with LATENCY=2: SW 0x12345678 @0x40, then LW @0x40 → `stall` high cycles 0..2, `done` in cycle 3, `rdata`=0x12345678.
- Sub-word store and load: SB 0x80 @0x41, then LB @0x41 → 0xFFFFFF80; LBU @0x41 → 0x00000080; LW @0x40 → 0x12348078.
- Half and wrap: SH 0xBEEF @0x1002 with DEPTH_WORDS=1024 → LW @0x0000 reads 0xBEEFxxxx, where the low half is unchanged; LH @0x2 → 0xFFFFBEEF.
- Simultaneous and illegal requests:
  - `mem_read`=`mem_write`=1, SW 0xA5A5A5A5 @0x80 → store performed, `rdata` unchanged.
  - `funct3`=011 load → `rdata`=0, `done` pulses.
- Misaligned (macro defined): LW @0x42 → `misaligned`=1 with `done`, `rdata`=0. SW @0x43 leaves the word unchanged. With the macro undefined, LW @0x42 returns word @0x40.
